// File: rtl/wb_regfile_pkg.sv
// Shared processor parameters for the writeback / register-file slice.
package wb_regfile_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned REGW  = 5;
endpackage

// File: rtl/regfile_core.sv
// Two-read, one-write register file with hard-wired zero register and write-through bypass.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int unsigned XLEN  = wb_regfile_pkg::XLEN,
  parameter int unsigned NREGS = wb_regfile_pkg::NREGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [REGW-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [REGW-1:0] raddr1,
  input  logic [REGW-1:0] raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_valid;

  assign wr_valid = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (wr_valid) begin
      regs[waddr] <= wdata;
    end
  end

  // A matching in-flight write wins over storage so decode sees it this cycle.
  always_comb begin
    rdata1 = '0;
    if (wr_valid && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else if (raddr1 != '0) begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (wr_valid && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else if (raddr2 != '0) begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register file, and committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned XLEN  = wb_regfile_pkg::XLEN,
  parameter int unsigned NREGS = wb_regfile_pkg::NREGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            regWriteW,
  input  logic            memToRegW,
  input  logic [XLEN-1:0] readDataW,
  input  logic [XLEN-1:0] ALUOutW,
  input  logic [REGW-1:0] writeRegW,
  input  logic [REGW-1:0] readReg1D,
  input  logic [REGW-1:0] readReg2D,
  output logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] readData1D,
  output logic [XLEN-1:0] readData2D,
  output logic [31:0]     wbCount
);

  logic [31:0] wb_cnt;

  assign resultW = memToRegW ? readDataW : ALUOutW;
  assign wbCount = wb_cnt;

  // Writes to register 0 are dropped by the core, so they must not count here either.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_cnt <= '0;
    end else if (regWriteW && (writeRegW != '0)) begin
      wb_cnt <= wb_cnt + 32'd1;
    end
  end

  regfile_core #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .we     (regWriteW),
    .waddr  (writeRegW),
    .wdata  (resultW),
    .raddr1 (readReg1D),
    .raddr2 (readReg2D),
    .rdata1 (readData1D),
    .rdata2 (readData2D)
  );

endmodule
